peripheral_noc_bus_arbiter: RTL

- Round-robin arbiter that shares the 16-bit peripheral bus (per_addr/per_din/per_en/per_we/per_dout) of the NoC peripheral among NUM_REQ requesters, e.g. the CPU, a DMA and debug.
- Sits between the requesters and the NoC peripheral instance.
- Sequences one single-beat access at a time, returns read data to the granted requester, and supports bounded bus locking for atomic read-modify-write sequences.

---
 rtl/peripheral_noc_bus_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/peripheral_noc_bus_arbiter.sv
// Round-robin arbiter sharing the NoC peripheral bus between requesters.
// One single-beat access at a time, with bounded lock for atomic sequences.
module peripheral_noc_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 4
) (
  input  logic                             mclk,
  input  logic                             puc_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_din,
  input  logic [NUM_REQ*2-1:0]             req_we,
  input  logic [NUM_REQ-1:0]               req_lock,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            per_addr,
  output logic [DATA_WIDTH-1:0]            per_din,
  output logic                             per_en,
  output logic [1:0]                       per_we,
  input  logic [DATA_WIDTH-1:0]            per_dout
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [3:0]            lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] per_addr_q, per_addr_d;
  logic [DATA_WIDTH-1:0] per_din_q, per_din_d;
  logic [1:0]            per_we_q, per_we_d;
  logic                  per_en_q, per_en_d;

  logic                  gnt_found;
  logic [IW-1:0]         gnt_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic [1:0]            sel_we;
  logic                  sel_lock;
  logic [3:0]            lock_base;

  // Round-robin scan starting at rr_ptr, first valid requester wins
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

  // Winner's command fields
  always_comb begin
    accept   = (state_q != ACCESS) && gnt_found;
    sel_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_din  = req_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_we   = req_we[int'(gnt_idx)*2 +: 2];
    sel_lock = req_lock[gnt_idx];
  end

  // State register
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and response outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    if (accept && puc_rst_n) req_ready[gnt_idx] = 1'b1;
    if (state_q == RESP) begin
      rsp_valid[gnt_q] = 1'b1;
      if (per_we_q == 2'b00) rsp_rdata = per_dout;
    end
  end

  // Pointer, lock counter and command register updates on accept
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    gnt_d      = gnt_q;
    per_addr_d = per_addr_q;
    per_din_d  = per_din_q;
    per_we_d   = per_we_q;
    per_en_d   = (state_d == ACCESS);
    lock_base  = (gnt_idx == gnt_q) ? lock_cnt_q : 4'd0;
    if (accept) begin
      gnt_d      = gnt_idx;
      per_addr_d = sel_addr;
      per_we_d   = sel_we;
      per_din_d  = (sel_we == 2'b00) ? '0 : sel_din;
      if (sel_lock && lock_base < 4'(LOCK_MAX - 1)) begin
        rr_ptr_d   = gnt_idx;
        lock_cnt_d = lock_base + 4'd1;
      end else begin
        rr_ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        lock_cnt_d = 4'd0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
      gnt_q      <= '0;
      per_addr_q <= '0;
      per_din_q  <= '0;
      per_we_q   <= '0;
      per_en_q   <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
      per_addr_q <= per_addr_d;
      per_din_q  <= per_din_d;
      per_we_q   <= per_we_d;
      per_en_q   <= per_en_d;
    end
  end

  assign per_addr = per_addr_q;
  assign per_din  = per_din_q;
  assign per_we   = per_we_q;
  assign per_en   = per_en_q;

endmodule
